clock_enable_scheduler: RTL and testbench

Programmable, multi-channel clock-enable generator and controller for the divided-clock resource. Holds one divide counter per channel, emits a single-cycle `tick_o` strobe and a 50%-duty divided `clk_o` per channel, and sequences ratio and enable changes through a valid/ready config port. Changes land only on a channel boundary, so divided outputs never glitch or truncate. Sits between the system control/register logic and every consumer of divided clocks or clock enables.

---
 rtl/clock_enable_scheduler_pkg.sv | 21 ++
 rtl/tick_channel.sv | 91 +++++++++
 rtl/clock_enable_scheduler.sv | 99 +++++++++
 tb/tb_clock_enable_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_enable_scheduler_pkg.sv
// Shared types and constants for the clock-enable scheduler.
// The per-channel config struct is sized by DIV_W_DFLT; the top-level DIV_W must match it.
package clock_enable_scheduler_pkg;

  localparam int DIV_W_DFLT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cfg_state_t;

  typedef struct packed {
    logic                  en;
    logic [DIV_W_DFLT-1:0] div;
  } ch_cfg_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One divide channel: counter, registered tick strobe and 50%-duty divided clock.
// Updates land only on a boundary so the divided clock never glitches.
module tick_channel
  import clock_enable_scheduler_pkg::*;
#(
  parameter int DIV_W = DIV_W_DFLT
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    apply_i,
  input  ch_cfg_t new_cfg_i,
  input  logic    sync_i,
  output logic    tick_o,
  output logic    clk_o,
  output logic    boundary_o
);

  logic             en_q, en_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             hit;

  assign hit        = en_q && (cnt_q == div_q);
  assign boundary_o = !en_q || hit || sync_i;
  assign tick_o     = tick_q;
  assign clk_o      = clk_q;

  always_comb begin
    en_d   = en_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (!en_q) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (apply_i) begin
        en_d  = new_cfg_i.en;
        div_d = new_cfg_i.div;
        // A freshly enabled channel treats the apply cycle itself as phase 0.
        if (new_cfg_i.en) begin
          if (new_cfg_i.div == '0) begin
            tick_d = 1'b1;
            clk_d  = 1'b1;
          end else begin
            cnt_d = DIV_W'(1);
          end
        end
      end
    end else if (sync_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (apply_i) begin
        en_d  = new_cfg_i.en;
        div_d = new_cfg_i.div;
      end
    end else begin
      tick_d = hit;
      cnt_d  = hit ? '0 : cnt_q + DIV_W'(1);
      clk_d  = hit ? ~clk_q : clk_q;
      if (apply_i) begin
        en_d  = new_cfg_i.en;
        div_d = new_cfg_i.div;
        cnt_d = '0;
        if (!new_cfg_i.en) begin
          tick_d = 1'b0;
          clk_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q   <= 1'b0;
      div_q  <= '0;
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      en_q   <= en_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/clock_enable_scheduler.sv
// Multi-channel clock-enable generator; config port holds one pending update at a time
// and releases it on the target channel's next boundary.
module clock_enable_scheduler
  import clock_enable_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = DIV_W_DFLT
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic [ch_width(NUM_CH)-1:0] cfg_ch_i,
  input  logic [DIV_W-1:0]            cfg_div_i,
  input  logic                        cfg_en_i,
  input  logic                        sync_i,
  output logic [NUM_CH-1:0]           tick_o,
  output logic [NUM_CH-1:0]           clk_o,
  output logic                        err_o
);

  localparam int              CH_W     = ch_width(NUM_CH);
  localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);

  cfg_state_t        state_q, state_d;
  logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
  ch_cfg_t           pend_cfg_q, pend_cfg_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] boundary;
  logic [NUM_CH-1:0] apply;
  logic              cfg_hs;
  logic              ch_invalid;

  assign cfg_ready_o = (state_q == IDLE);
  assign err_o       = err_q;
  assign cfg_hs      = cfg_valid_i && (state_q == IDLE);
  assign ch_invalid  = ({1'b0, cfg_ch_i} >= NUM_CH_L);

  always_comb begin
    apply = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      apply[i] = (state_q == PEND) && (pend_ch_q == CH_W'(i)) && boundary[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_ch_d  = pend_ch_q;
    pend_cfg_d = pend_cfg_q;
    err_d      = 1'b0;
    if (state_q == IDLE) begin
      if (cfg_hs) begin
        // Out-of-range targets are consumed so the requester never stalls on them.
        if (ch_invalid) begin
          err_d = 1'b1;
        end else begin
          pend_ch_d      = cfg_ch_i;
          pend_cfg_d.en  = cfg_en_i;
          pend_cfg_d.div = cfg_div_i;
          state_d        = PEND;
        end
      end
    end else begin
      if (|apply) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pend_ch_q  <= '0;
      pend_cfg_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_ch_q  <= pend_ch_d;
      pend_cfg_q <= pend_cfg_d;
      err_q      <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .apply_i    (apply[g]),
      .new_cfg_i  (pend_cfg_q),
      .sync_i     (sync_i),
      .tick_o     (tick_o[g]),
      .clk_o      (clk_o[g]),
      .boundary_o (boundary[g])
    );
  end

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Directed bench: main instance with 4 channels, second instance with 3 channels
// so that an out-of-range channel index is expressible on the 2-bit port.
module tb_clock_enable_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic        cfg_en = 1'b0;
  logic        sync = 1'b0;
  logic [3:0]  tick;
  logic [3:0]  clk_div;
  logic        err;

  logic        v3 = 1'b0;
  logic        ready3;
  logic [1:0]  ch3 = '0;
  logic [15:0] div3 = '0;
  logic        en3 = 1'b0;
  logic [2:0]  tick3;
  logic [2:0]  clk3;
  logic        err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_enable_scheduler #(.NUM_CH(4), .DIV_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_ch_i(cfg_ch), .cfg_div_i(cfg_div), .cfg_en_i(cfg_en), .sync_i(sync),
    .tick_o(tick), .clk_o(clk_div), .err_o(err)
  );

  clock_enable_scheduler #(.NUM_CH(3), .DIV_W(16)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(v3), .cfg_ready_o(ready3),
    .cfg_ch_i(ch3), .cfg_div_i(div3), .cfg_en_i(en3), .sync_i(1'b0),
    .tick_o(tick3), .clk_o(clk3), .err_o(err3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [15:0] div, input logic en);
    int n;
    n = 0;
    while (!cfg_ready && n < 40) begin
      step();
      n++;
    end
    if (!cfg_ready) begin
      checks++; errors++;
      $display("FAIL cfg_wait: ready=%0b required 1", cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = div;
    cfg_en    = en;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({cfg_ready, tick, clk_div, err} !== 10'b1_0000_0000_0) begin
      errors++;
      $display("FAIL reset_in: rdy/tick/clk/err=%b required 1000000000", {cfg_ready, tick, clk_div, err});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({cfg_ready, tick, clk_div, err, ready3, tick3, clk3, err3} !== 18'b1_0000_0000_0_1_000_000_0) begin
      errors++;
      $display("FAIL reset_out: got %b required 100000000010000000",
               {cfg_ready, tick, clk_div, err, ready3, tick3, clk3, err3});
    end
  endtask

  task automatic test_enable_d0();
    logic exp_clk;
    cfg(2'd0, 16'd0, 1'b1);
    checks++;
    if (cfg_ready !== 1'b0 || tick[0] !== 1'b0) begin
      errors++;
      $display("FAIL en_d0_pend: ready=%b tick0=%b required 0 0", cfg_ready, tick[0]);
    end
    step();
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL en_d0_ready: ready=%b required 1", cfg_ready);
    end
    for (int k = 0; k < 4; k++) begin
      exp_clk = (k % 2 == 0);
      checks++;
      if (tick[0] !== 1'b1 || clk_div[0] !== exp_clk) begin
        errors++;
        $display("FAIL en_d0_run%0d: tick0=%b clk0=%b required 1 %b", k, tick[0], clk_div[0], exp_clk);
      end
      step();
    end
  endtask

  task automatic test_ratio_change();
    logic [5:0] exp_tick;
    logic [5:0] exp_clk;
    exp_tick = 6'b101010;
    exp_clk  = 6'b100110;
    cfg(2'd1, 16'd3, 1'b1);
    repeat (3) step();
    checks++;
    if (tick[1] !== 1'b0) begin
      errors++;
      $display("FAIL ratio_early: tick1=%b required 0", tick[1]);
    end
    step();
    checks++;
    if (tick[1] !== 1'b1 || clk_div[1] !== 1'b1) begin
      errors++;
      $display("FAIL ratio_first_tick: tick1=%b clk1=%b required 1 1", tick[1], clk_div[1]);
    end
    step();
    cfg(2'd1, 16'd1, 1'b1);
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL ratio_stall_a: ready=%b required 0", cfg_ready);
    end
    step();
    checks++;
    if (cfg_ready !== 1'b0 || tick[1] !== 1'b0) begin
      errors++;
      $display("FAIL ratio_stall_b: ready=%b tick1=%b required 0 0", cfg_ready, tick[1]);
    end
    step();
    checks++;
    if (cfg_ready !== 1'b1 || tick[1] !== 1'b1 || clk_div[1] !== 1'b0) begin
      errors++;
      $display("FAIL ratio_boundary: ready=%b tick1=%b clk1=%b required 1 1 0", cfg_ready, tick[1], clk_div[1]);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (tick[1] !== exp_tick[k] || clk_div[1] !== exp_clk[k]) begin
        errors++;
        $display("FAIL ratio_new%0d: tick1=%b clk1=%b required %b %b", k, tick[1], clk_div[1], exp_tick[k], exp_clk[k]);
      end
    end
  endtask

  task automatic test_sync();
    logic [1:0] exp;
    cfg(2'd0, 16'd2, 1'b1);
    cfg(2'd2, 16'd4, 1'b1);
    step();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++;
    if (clk_div[2:0] !== 3'b000 || tick[2:0] !== 3'b000) begin
      errors++;
      $display("FAIL sync_align: clk=%b tick=%b required 000 000", clk_div[2:0], tick[2:0]);
    end
    for (int k = 2; k <= 6; k++) begin
      step();
      exp = {k == 6, k == 4};
      checks++;
      if ({tick[2], tick[0]} !== exp) begin
        errors++;
        $display("FAIL sync_tick_s%0d: tick2,tick0=%b required %b", k, {tick[2], tick[0]}, exp);
      end
      if (k == 3) begin
        checks++;
        if (tick[1] !== 1'b1) begin
          errors++;
          $display("FAIL sync_ch1: tick1=%b required 1", tick[1]);
        end
      end
    end
  endtask

  task automatic test_disable();
    logic seen;
    cfg(2'd3, 16'd7, 1'b1);
    repeat (8) step();
    checks++;
    if (tick[3] !== 1'b1 || clk_div[3] !== 1'b1) begin
      errors++;
      $display("FAIL dis_first_tick: tick3=%b clk3=%b required 1 1", tick[3], clk_div[3]);
    end
    step();
    cfg(2'd3, 16'd7, 1'b0);
    repeat (5) step();
    checks++;
    if (cfg_ready !== 1'b0 || clk_div[3] !== 1'b1) begin
      errors++;
      $display("FAIL dis_stall: ready=%b clk3=%b required 0 1", cfg_ready, clk_div[3]);
    end
    step();
    checks++;
    if (cfg_ready !== 1'b1 || tick[3] !== 1'b0 || clk_div[3] !== 1'b0) begin
      errors++;
      $display("FAIL dis_boundary: ready=%b tick3=%b clk3=%b required 1 0 0", cfg_ready, tick[3], clk_div[3]);
    end
    seen = 1'b0;
    repeat (10) begin
      step();
      seen = seen | tick[3] | clk_div[3];
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL dis_quiet: activity=%b required 0", seen);
    end
    cfg(2'd3, 16'd7, 1'b1);
    repeat (7) step();
    checks++;
    if (tick[3] !== 1'b0) begin
      errors++;
      $display("FAIL reen_early: tick3=%b required 0", tick[3]);
    end
    step();
    checks++;
    if (tick[3] !== 1'b1) begin
      errors++;
      $display("FAIL reen_tick: tick3=%b required 1", tick[3]);
    end
  endtask

  task automatic test_invalid();
    int pulses;
    logic rdy_low;
    logic act;
    pulses  = 0;
    rdy_low = 1'b0;
    act     = 1'b0;
    v3   = 1'b1;
    ch3  = 2'd3;
    div3 = 16'd5;
    en3  = 1'b1;
    step();
    v3 = 1'b0;
    repeat (6) begin
      if (err3) pulses++;
      rdy_low = rdy_low | ~ready3;
      act     = act | (|tick3) | (|clk3);
      step();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL inv_err: pulses=%0d required 1", pulses);
    end
    checks++;
    if (rdy_low !== 1'b0 || act !== 1'b0) begin
      errors++;
      $display("FAIL inv_side: ready_dropped=%b activity=%b required 0 0", rdy_low, act);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL inv_main_err: err=%b required 0", err);
    end
  endtask

  task automatic test_reset_pend();
    logic seen;
    cfg(2'd2, 16'd0, 1'b1);
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL rp_pending: ready=%b required 0", cfg_ready);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({cfg_ready, tick, clk_div, err} !== 10'b1_0000_0000_0) begin
      errors++;
      $display("FAIL rp_reset: rdy/tick/clk/err=%b required 1000000000", {cfg_ready, tick, clk_div, err});
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      step();
      seen = seen | (|tick) | (|clk_div) | ~cfg_ready;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rp_discard: activity=%b required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_enable_d0();
    test_ratio_change();
    test_sync();
    test_disable();
    test_invalid();
    test_reset_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
